// File: rtl/prio_req_encoder_pkg.sv
// Shared constants for the registered priority request encoder.
package prio_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_req_encoder_if.sv
// Request/grant bundle between event sources, the encoder and its consumer.
interface prio_req_encoder_if
  import prio_pkg::*;
#(
  parameter int unsigned N = 8
);
  localparam int unsigned IDX_W = idx_width(N);

  logic [N-1:0]     req;
  logic             flush;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     pending;

  modport master (
    output req, flush, out_ready,
    input  out_idx, out_valid, pending
  );

  modport slave (
    input  req, flush, out_ready,
    output out_idx, out_valid, pending
  );
endinterface

// File: rtl/prio_req_encoder_find_msb.sv
// First set bit of vec, scanning downward from start and wrapping at bit 0.
module prio_find_msb
  import prio_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(start) + N - i) % N;
      if (!found && vec[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_req_encoder.sv
// Captures request pulses into a pending vector and hands out one encoded index
// per valid/ready handshake, fixed-priority (MSB first) or round-robin.
module prio_req_encoder
  import prio_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned MODE = MODE_FIXED
) (
  input logic              clk,
  input logic              rst_n,
  prio_req_encoder_if.slave bus
);

  localparam int unsigned      IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  logic [N-1:0]     pending_q;
  logic [N-1:0]     cand;
  logic [N-1:0]     onehot;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic             valid_q;
  logic             found;
  logic             slot_free;

  assign cand      = pending_q | bus.req;
  assign slot_free = !valid_q || bus.out_ready;
  assign start     = (MODE == MODE_RR) ? rr_ptr : LAST;

  prio_find_msb #(.N(N)) u_find (
    .vec   (cand),
    .start (start),
    .found (found),
    .idx   (sel)
  );

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

  // The granted bit leaves cand here, so a req arriving with its own grant is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      rr_ptr    <= LAST;
    end else if (bus.flush) begin
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      rr_ptr    <= LAST;
    end else if (slot_free && found) begin
      idx_q     <= sel;
      valid_q   <= 1'b1;
      pending_q <= cand & ~onehot;
      rr_ptr    <= (sel == '0) ? LAST : sel - 1'b1;
    end else begin
      pending_q <= cand;
      if (slot_free) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_prio_req_encoder.sv
// Bench for prio_req_encoder: directed vector table, async-reset sequence and
// randomized traffic against a behavioural model on three configurations.
module tb_prio_req_encoder;
  import prio_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_req_encoder_if #(.N(8)) if0 ();
  prio_req_encoder_if #(.N(8)) if1 ();
  prio_req_encoder_if #(.N(6)) if2 ();

  prio_req_encoder #(.N(8), .MODE(MODE_FIXED)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  prio_req_encoder #(.N(8), .MODE(MODE_RR))    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  prio_req_encoder #(.N(6), .MODE(MODE_RR))    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int pass_cnt  = 0;
  int total_cnt = 0;

  int m_pend[3], m_valid[3], m_idx[3], m_ptr[3];
  int c_req[3], c_rdy[3], c_fl[3];

  typedef struct {
    int rst; int dut; int req; int rdy; int fl;
    int v;   int idx; int pend;
  } vec_t;
  vec_t vecs[$];

  function automatic int n_of(input int d);
    return (d == 2) ? 6 : 8;
  endfunction

  function automatic int mode_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic vec_t mk(input int rst, input int dut, input int req, input int rdy,
                              input int fl, input int v, input int idx, input int pend);
    vec_t t;
    t.rst = rst; t.dut = dut; t.req = req; t.rdy = rdy; t.fl = fl;
    t.v = v; t.idx = idx; t.pend = pend;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int get_valid(input int d);
    case (d)
      0:       return int'(if0.out_valid);
      1:       return int'(if1.out_valid);
      default: return int'(if2.out_valid);
    endcase
  endfunction

  function automatic int get_idx(input int d);
    case (d)
      0:       return int'(if0.out_idx);
      1:       return int'(if1.out_idx);
      default: return int'(if2.out_idx);
    endcase
  endfunction

  function automatic int get_pend(input int d);
    case (d)
      0:       return int'(if0.pending);
      1:       return int'(if1.pending);
      default: return int'(if2.pending);
    endcase
  endfunction

  task automatic drive(input int d, input int r, input int rdy, input int fl);
    c_req[d] = r; c_rdy[d] = rdy; c_fl[d] = fl;
    case (d)
      0: begin if0.req = 8'(r); if0.out_ready = 1'(rdy); if0.flush = 1'(fl); end
      1: begin if1.req = 8'(r); if1.out_ready = 1'(rdy); if1.flush = 1'(fl); end
      default: begin if2.req = 6'(r); if2.out_ready = 1'(rdy); if2.flush = 1'(fl); end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_pend[d] = 0; m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = n_of(d) - 1;
    end
  endtask

  // Reference: walk the priority order from the top (or from the RR pointer) and take
  // the first requester; the consumer's handshake decides whether a new grant may issue.
  task automatic model_step(input int d);
    int n, cand, k, first;
    n = n_of(d);
    if (c_fl[d] != 0) begin
      m_pend[d] = 0; m_valid[d] = 0; m_idx[d] = 0; m_ptr[d] = n - 1;
      return;
    end
    cand = m_pend[d] | c_req[d];
    if (m_valid[d] == 0 || c_rdy[d] != 0) begin
      first = (mode_of(d) == 1) ? m_ptr[d] : n - 1;
      k = -1;
      for (int s = 0; s < n; s++) begin
        int p;
        p = (first - s + n) % n;
        if (k < 0 && ((cand >> p) & 1) != 0) k = p;
      end
      if (k >= 0) begin
        m_idx[d] = k; m_valid[d] = 1;
        m_pend[d] = cand & ~(1 << k);
        m_ptr[d] = (k == 0) ? n - 1 : k - 1;
      end else begin
        m_valid[d] = 0; m_pend[d] = cand;
      end
    end else begin
      m_pend[d] = cand;
    end
  endtask

  task automatic cycle();
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int d, r, rdy, fl, n;

    // fixed priority: 0A drain, 81 stall, duplicate/re-pend, pulse collapse
    vecs.push_back(mk(1, 0, 'h0A, 1, 0, 1, 3, 'h02));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 1, 1, 'h00));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h81, 0, 0, 1, 7, 'h01));
    vecs.push_back(mk(0, 0, 'h00, 0, 0, 1, 7, 'h01));
    vecs.push_back(mk(0, 0, 'h00, 0, 0, 1, 7, 'h01));
    vecs.push_back(mk(0, 0, 'h00, 0, 0, 1, 7, 'h01));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 1, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h01, 0, 0, 1, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h01, 0, 0, 1, 0, 'h01));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 1, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h01, 1, 0, 1, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 'h04, 0, 0, 1, 2, 'h00));
    vecs.push_back(mk(0, 0, 'h10, 0, 0, 1, 2, 'h10));
    vecs.push_back(mk(0, 0, 'h10, 0, 0, 1, 2, 'h10));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 1, 4, 'h00));
    vecs.push_back(mk(0, 0, 'h00, 1, 0, 0, 0, 'h00));
    // round-robin: FF held ten cycles
    vecs.push_back(mk(1, 1, 'hFF, 1, 0, 1, 7, 'h7F));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 6, 'hBF));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 5, 'hDF));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 4, 'hEF));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 3, 'hF7));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 2, 'hFB));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 1, 'hFD));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 0, 'hFE));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 7, 'h7F));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 6, 'hBF));
    // round-robin skip from pointer 2 over 88, then flush with 3C pending
    vecs.push_back(mk(1, 1, 'h08, 0, 0, 1, 3, 'h00));
    vecs.push_back(mk(0, 1, 'h88, 0, 0, 1, 3, 'h88));
    vecs.push_back(mk(0, 1, 'h00, 1, 0, 1, 7, 'h08));
    vecs.push_back(mk(0, 1, 'h00, 1, 0, 1, 3, 'h00));
    vecs.push_back(mk(0, 1, 'h00, 1, 0, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h3C, 0, 0, 1, 2, 'h38));
    vecs.push_back(mk(0, 1, 'h04, 0, 0, 1, 2, 'h3C));
    vecs.push_back(mk(0, 1, 'h01, 0, 1, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'hFF, 1, 0, 1, 7, 'h7F));
    vecs.push_back(mk(0, 1, 'h00, 1, 0, 1, 6, 'h3F));

    for (int i = 0; i < 3; i++) drive(i, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d valid", i), get_valid(i), 0);
      check($sformatf("reset%0d idx", i), get_idx(i), 0);
      check($sformatf("reset%0d pending", i), get_pend(i), 0);
    end
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst != 0) do_reset();
      d = vecs[i].dut;
      for (int j = 0; j < 3; j++) drive(j, 0, 1, 0);
      drive(d, vecs[i].req, vecs[i].rdy, vecs[i].fl);
      cycle();
      check($sformatf("vec%0d valid", i), get_valid(d), vecs[i].v);
      check($sformatf("vec%0d pending", i), get_pend(d), vecs[i].pend);
      if (vecs[i].v != 0 || vecs[i].fl != 0)
        check($sformatf("vec%0d idx", i), get_idx(d), vecs[i].idx);
    end

    // asynchronous reset in the middle of a stall
    for (int j = 0; j < 3; j++) drive(j, 0, 1, 0);
    drive(0, 'h81, 0, 0);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    check("stall idx", get_idx(0), 7);
    check("stall pending", get_pend(0), 'h01);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async%0d valid", i), get_valid(i), 0);
      check($sformatf("async%0d idx", i), get_idx(i), 0);
      check($sformatf("async%0d pending", i), get_pend(i), 0);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    drive(0, 'h10, 1, 0);
    cycle();
    check("post-reset valid", get_valid(0), 1);
    check("post-reset idx", get_idx(0), 4);

    // randomized traffic on all three configurations
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 3; j++) begin
        n   = n_of(j);
        r   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (1 << n) - 1)) : 0;
        rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
        fl  = ($urandom_range(0, 40) == 0) ? 1 : 0;
        drive(j, r, rdy, fl);
      end
      cycle();
      for (int j = 0; j < 3; j++) begin
        check($sformatf("rnd%0d dut%0d valid", c, j), get_valid(j), m_valid[j]);
        check($sformatf("rnd%0d dut%0d pending", c, j), get_pend(j), m_pend[j]);
        if (m_valid[j] != 0)
          check($sformatf("rnd%0d dut%0d idx", c, j), get_idx(j), m_idx[j]);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
